// File: rtl/alu_mul_sequencer_pkg.sv
// Shared types and constants for the ALU-driven shift-and-add multiplier.
// FunSel table mirrors the ArithmeticLogicUnit: bit 4 selects 16-bit operation.
package alu_mul_sequencer_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned FUNSEL_W  = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  localparam logic [FUNSEL_W-1:0] FS_A8     = 5'b00000;
  localparam logic [FUNSEL_W-1:0] FS_B8     = 5'b00001;
  localparam logic [FUNSEL_W-1:0] FS_NOTA8  = 5'b00010;
  localparam logic [FUNSEL_W-1:0] FS_NOTB8  = 5'b00011;
  localparam logic [FUNSEL_W-1:0] FS_ADD8   = 5'b00100;
  localparam logic [FUNSEL_W-1:0] FS_ADDC8  = 5'b00101;
  localparam logic [FUNSEL_W-1:0] FS_SUB8   = 5'b00110;
  localparam logic [FUNSEL_W-1:0] FS_AND8   = 5'b00111;
  localparam logic [FUNSEL_W-1:0] FS_OR8    = 5'b01000;
  localparam logic [FUNSEL_W-1:0] FS_XOR8   = 5'b01001;
  localparam logic [FUNSEL_W-1:0] FS_NAND8  = 5'b01010;
  localparam logic [FUNSEL_W-1:0] FS_LSL8   = 5'b01011;
  localparam logic [FUNSEL_W-1:0] FS_LSR8   = 5'b01100;
  localparam logic [FUNSEL_W-1:0] FS_ASR8   = 5'b01101;
  localparam logic [FUNSEL_W-1:0] FS_CSL8   = 5'b01110;
  localparam logic [FUNSEL_W-1:0] FS_CSR8   = 5'b01111;
  localparam logic [FUNSEL_W-1:0] FS_A16    = 5'b10000;
  localparam logic [FUNSEL_W-1:0] FS_B16    = 5'b10001;
  localparam logic [FUNSEL_W-1:0] FS_NOTA16 = 5'b10010;
  localparam logic [FUNSEL_W-1:0] FS_NOTB16 = 5'b10011;
  localparam logic [FUNSEL_W-1:0] FS_ADD16  = 5'b10100;
  localparam logic [FUNSEL_W-1:0] FS_ADDC16 = 5'b10101;
  localparam logic [FUNSEL_W-1:0] FS_SUB16  = 5'b10110;
  localparam logic [FUNSEL_W-1:0] FS_AND16  = 5'b10111;
  localparam logic [FUNSEL_W-1:0] FS_OR16   = 5'b11000;
  localparam logic [FUNSEL_W-1:0] FS_XOR16  = 5'b11001;
  localparam logic [FUNSEL_W-1:0] FS_NAND16 = 5'b11010;
  localparam logic [FUNSEL_W-1:0] FS_LSL16  = 5'b11011;
  localparam logic [FUNSEL_W-1:0] FS_LSR16  = 5'b11100;
  localparam logic [FUNSEL_W-1:0] FS_ASR16  = 5'b11101;
  localparam logic [FUNSEL_W-1:0] FS_CSL16  = 5'b11110;
  localparam logic [FUNSEL_W-1:0] FS_CSR16  = 5'b11111;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Unsigned WIDTHxWIDTH shift-and-add multiplier that borrows the shared ALU
// for every addition; shifting and carry reconstruction are done locally.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int unsigned          WIDTH      = DEF_WIDTH,
  parameter int unsigned          ALU_LAT    = 1,
  parameter logic [FUNSEL_W-1:0]  ADD_FUNSEL = FS_ADD16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Op1,
  input  logic [WIDTH-1:0]      Op2,
  output logic                  Busy,
  output logic                  Done,
  output logic [2*WIDTH-1:0]    Product,
  output logic                  ProdZero,
  output logic                  AluOwn,
  output logic [WIDTH-1:0]      AluA,
  output logic [WIDTH-1:0]      AluB,
  output logic [FUNSEL_W-1:0]   AluFunSel,
  output logic                  AluWF,
  input  logic [WIDTH-1:0]      AluOut
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  seq_state_t state, next_state;

  logic [WIDTH-1:0] m, q, p;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic [LAT_W-1:0] wait_cnt;

  logic             wait_last, cnt_last, add_carry;
  logic [WIDTH-1:0] p_shift, q_shift;

  assign wait_last = (wait_cnt == LAT_W'(ALU_LAT - 1));
  assign cnt_last  = (cnt == CNT_W'(WIDTH - 1));
  // ALU adds modulo 2^WIDTH; a wrapped sum is smaller than the old high word.
  assign add_carry = (AluOut < p);
  assign p_shift   = {cy, p[WIDTH-1:1]};
  assign q_shift   = {p[0], q[WIDTH-1:1]};

  // Flags in the ALU belong to the program, never to the multiplier.
  assign AluWF = 1'b0;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = TEST;
      TEST:    next_state = q[0] ? ISSUE : SHIFT;
      ISSUE:   next_state = WAIT;
      WAIT:    if (wait_last) next_state = SHIFT;
      SHIFT:   next_state = cnt_last ? DONE : TEST;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs, all keyed off the upcoming state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      m         <= '0;
      q         <= '0;
      p         <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      wait_cnt  <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Product   <= '0;
      ProdZero  <= 1'b1;
      AluOwn    <= 1'b0;
      AluA      <= '0;
      AluB      <= '0;
      AluFunSel <= '0;
    end else begin
      Busy   <= (next_state != IDLE);
      Done   <= (next_state == DONE);
      AluOwn <= (next_state == ISSUE) || (next_state == WAIT);
      case (state)
        IDLE: begin
          if (Start) begin
            m   <= Op1;
            q   <= Op2;
            p   <= '0;
            cy  <= 1'b0;
            cnt <= '0;
          end
        end
        TEST: begin
          if (q[0]) begin
            AluA      <= p;
            AluB      <= m;
            AluFunSel <= ADD_FUNSEL;
            wait_cnt  <= '0;
          end else begin
            cy <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_last) begin
            p  <= AluOut;
            cy <= add_carry;
          end else begin
            wait_cnt <= wait_cnt + LAT_W'(1);
          end
        end
        SHIFT: begin
          p   <= p_shift;
          q   <= q_shift;
          cy  <= 1'b0;
          cnt <= cnt + CNT_W'(1);
          if (cnt_last) begin
            Product  <= {p_shift, q_shift};
            ProdZero <= ({p_shift, q_shift} == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
